axi_write_buffer: RTL and testbench
===================================

Name: axi_write_buffer

Overview:
- Posted-write buffer between the data-side SRAM-like write path and AXI slave port 0 of the top-level crossbar (AW/W/B channels only).
- Accepts single-word stores into a FIFO and acknowledges each in one cycle. Drains the FIFO as single-beat AXI write bursts, one outstanding transaction at a time.
- Exposes an address-match query so the data path can stall a load that hits a pending store, plus an empty flag for SYNC/uncached ordering.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- AXI_ID, 4'd1, constant value driven on awid and wid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wb_req  in  1  store request valid
- wb_addr  in  32  byte address
- wb_wdata  in  32  store data, already lane-aligned
- wb_wstrb  in  4  byte enables
- wb_size  in  3  AXI size code (0=byte, 1=half, 2=word)
- wb_addr_ok  out  1  request accepted this cycle
- wb_empty  out  1  FIFO empty and no transaction in flight
- q_addr  in  32  load address to check
- q_hit  out  1  q_addr[31:2] matches any occupied entry
- awid  out  4  write address ID
- awaddr  out  32  write address
- awlen  out  4  burst length
- awsize  out  3  burst size
- awburst  out  2  burst type
- awlock  out  2  lock
- awcache  out  4  cache attributes
- awprot  out  3  protection
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wid  out  4  write data ID
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wlast  out  1  last beat
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bid  in  4  response ID
- bresp  in  2  response code
- bvalid  in  1  response valid
- bready  out  1  response ready

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: count=0, pointers=0, state=IDLE, awvalid=0, wvalid=0, bready=0. wb_empty=1 and wb_addr_ok=1 during and after reset.
- Constant AXI fields: awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wlast=1, awid=wid=AXI_ID.
- Entry format: {addr[31:0], wdata, wstrb, size}. awaddr/wdata/wstrb/awsize come combinationally from the head entry; awsize = size.
- Push: wb_addr_ok = (count != DEPTH), combinational from registered count.
  - A push occurs when wb_req & wb_addr_ok.
  - The entry is written at wr_ptr and is visible to q_hit the next cycle.
  - wb_addr_ok is the only acknowledgement; there is no data_ok for stores.
- FSM states:
  - IDLE: if count != 0, go to SEND and assert awvalid=1 and wvalid=1 the next cycle.
  - SEND: awvalid and wvalid are tracked independently.
    - awvalid drops after the awready handshake; wvalid drops after the wready handshake.
    - Both may complete in the same or different cycles, in either order.
    - When both are done, go to RESP.
  - RESP: bready=1. On bvalid, pop the head (rd_ptr+1, count-1) and return to IDLE.
    - bresp and bid are ignored; errors are not reported.
- Throughput: at most one write per 3 cycles with zero-wait slaves (IDLE, SEND, RESP).
- The head entry is not popped until B is received, so it stays occupied and visible to q_hit while in flight.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full: wb_addr_ok=0 and the request is ignored. A push is not accepted in the same cycle as a pop from full; it is accepted the following cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- wb_empty = (count==0) & (state==IDLE).
- q_hit is combinational: OR over occupied entries of (entry.addr[31:2]==q_addr[31:2]). Occupancy is derived from rd_ptr/count, not stale data. q_hit=0 when empty.
- rst asserted mid-transaction: all state is cleared immediately. The downstream slave is reset by the same domain; no drain occurs.

Decomposition:
- Shared package/defines: AXI constants (BURST_INCR, SIZE_WORD, LEN_SINGLE), the FSM state encodings (IDLE/SEND/RESP), and the entry field widths.
- One sub-module, wb_fifo: storage, pointers, count, full/empty, per-entry occupied vector, and q_hit compare.
- axi_write_buffer holds the AXI FSM and the port mapping.

Test Plan:
- Single store addr=0x8000_0010, data=0xDEADBEEF, strb=4'hF: wb_addr_ok=1 that cycle. Next cycle awvalid=wvalid=1 with awaddr=0x8000_0010, awlen=0, wlast=1. After bvalid, wb_empty=1.
- Five back-to-back stores with awready=wready=bvalid held low: four accepted, fifth sees wb_addr_ok=0. Release the slave: AXI writes appear in FIFO order, and the fifth is accepted after the first B.
- awready in cycle N, wready in cycle N+3: awvalid drops after N, wvalid stays high until N+3, and bready rises only after both handshakes.
- Store to 0x1000_0004 pending, q_addr=0x1000_0007: q_hit=1. q_addr=0x1000_0008: q_hit=0. After B for that entry completes: q_hit=0.
- Full FIFO, pop (bvalid) and wb_req in the same cycle: wb_addr_ok=0 that cycle and 1 the next. Count ends at DEPTH, with pointers wrapped past index DEPTH-1 back to 0.
- rst asserted while in SEND with awvalid=1: next cycle awvalid=wvalid=bready=0, wb_empty=1, q_hit=0.

Source files
------------

// File: rtl/axi_write_buffer_pkg.sv
// axi_write_buffer_pkg: AXI constants, FSM encodings and FIFO entry layout for the posted-write buffer
package axi_write_buffer_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [3:0] LEN_SINGLE = 4'd0;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int SIZE_W = 3;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [SIZE_W-1:0] size;
    } entry_t;
endpackage

// File: rtl/axi_write_buffer_fifo.sv
// wb_fifo: store FIFO with occupancy tracking and word-address match against all pending entries
module wb_fifo
    import axi_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  entry_t      din,
    output entry_t      head,
    output logic        full,
    output logic        empty,
    input  logic [29:0] q_word,
    output logic        q_hit
);
    localparam int AW = $clog2(DEPTH);
    entry_t            mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [DEPTH-1:0]  occ;
    logic [DEPTH-1:0]  match;
    // pointers wrap naturally; count moves only when push and pop differ
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // storage needs no reset: occupancy comes from rd_ptr/count, never from stale contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [AW-1:0] off;
        assign off      = AW'(i) - rd_ptr;
        assign occ[i]   = {1'b0, off} < cnt;
        assign match[i] = mem[i].addr[31:2] == q_word;
    end
    assign head  = mem[rd_ptr];
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign q_hit = |(occ & match);
endmodule

// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted store FIFO drained as single-beat AXI writes, one outstanding at a time
module axi_write_buffer
    import axi_write_buffer_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_req,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wdata,
    input  logic [3:0]  wb_wstrb,
    input  logic [2:0]  wb_size,
    output logic        wb_addr_ok,
    output logic        wb_empty,
    input  logic [31:0] q_addr,
    output logic        q_hit,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    logic [1:0] state;
    logic       full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       unused;
    entry_t     wr_entry;
    entry_t     head;
    assign wr_entry   = '{addr: wb_addr, data: wb_wdata, strb: wb_wstrb, size: wb_size};
    assign wb_addr_ok = !full;
    assign push       = wb_req && !full;
    assign pop        = state == ST_RESP && bvalid;
    assign bready     = state == ST_RESP;
    assign wb_empty   = fifo_empty && state == ST_IDLE;
    assign unused     = ^{bid, bresp, q_addr[1:0]};
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .din    (wr_entry),
        .head   (head),
        .full   (full),
        .empty  (fifo_empty),
        .q_word (q_addr[31:2]),
        .q_hit  (q_hit)
    );
    // AW and W handshakes complete independently; head stays queued until B arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty) begin
                    state   <= ST_SEND;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                end
                ST_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready) wvalid <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) state <= ST_RESP;
                end
                ST_RESP: if (bvalid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign awaddr  = head.addr;
    assign awsize  = head.size;
    assign wdata   = head.data;
    assign wstrb   = head.strb;
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wlast   = 1'b1;
endmodule

// File: tb/tb_axi_write_buffer.sv
// tb_axi_write_buffer: directed scenarios plus randomized traffic against a queue-based store model
module tb_axi_write_buffer;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } st_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_wstrb;
    logic [2:0]  wb_size;
    logic        wb_addr_ok;
    logic        wb_empty;
    logic [31:0] q_addr;
    logic        q_hit;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    int          n_cmp = 0;
    int          n_err = 0;

    axi_write_buffer #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .wb_req(wb_req), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_wstrb(wb_wstrb), .wb_size(wb_size), .wb_addr_ok(wb_addr_ok), .wb_empty(wb_empty),
        .q_addr(q_addr), .q_hit(q_hit), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_req = 1'b0; wb_addr = '0; wb_wdata = '0; wb_wstrb = '0; wb_size = '0;
        q_addr = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        tick(); tick();
        n_cmp++;
        if ({awvalid, wvalid, bready, wb_empty, wb_addr_ok, q_hit} !== 6'b000110) begin
            n_err++; $display("FAIL reset_during got %b exp 000110", {awvalid, wvalid, bready, wb_empty, wb_addr_ok, q_hit});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({awvalid, wvalid, bready, wb_empty, wb_addr_ok, q_hit} !== 6'b000110) begin
            n_err++; $display("FAIL reset_after got %b exp 000110", {awvalid, wvalid, bready, wb_empty, wb_addr_ok, q_hit});
        end
    endtask

    task automatic test_single();
        wb_req = 1'b1; wb_addr = 32'h8000_0010; wb_wdata = 32'hDEAD_BEEF; wb_wstrb = 4'hF; wb_size = 3'd2;
        #1;
        n_cmp++;
        if (wb_addr_ok !== 1'b1) begin n_err++; $display("FAIL single_ok got %b exp 1", wb_addr_ok); end
        tick();
        wb_req = 1'b0;
        for (int k = 0; k < 4 && !awvalid; k++) tick();
        n_cmp++;
        if ({awvalid, wvalid} !== 2'b11) begin n_err++; $display("FAIL single_valid got %b exp 11", {awvalid, wvalid}); end
        n_cmp++;
        if ({awaddr, awlen, wlast, awsize, awburst, awid, wid, wdata, wstrb, awlock, awcache, awprot} !==
            {32'h8000_0010, 4'd0, 1'b1, 3'd2, 2'b01, 4'd1, 4'd1, 32'hDEAD_BEEF, 4'hF, 2'b0, 4'b0, 3'b0}) begin
            n_err++; $display("FAIL single_fields got addr %h len %h last %b size %h data %h", awaddr, awlen, wlast, awsize, wdata);
        end
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++; $display("FAIL single_resp got %b exp 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        n_cmp++;
        if (wb_empty !== 1'b1) begin n_err++; $display("FAIL single_empty got %b exp 1", wb_empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [5];
        logic [31:0] d [5];
        for (int i = 0; i < 5; i++) begin
            a[i] = 32'h2000_0000 + 32'(i * 16);
            d[i] = $urandom;
            wb_req = 1'b1; wb_addr = a[i]; wb_wdata = d[i]; wb_wstrb = 4'hF; wb_size = 3'd2;
            #1;
            n_cmp++;
            if (wb_addr_ok !== (i < 4)) begin n_err++; $display("FAIL fill_ok[%0d] got %b exp %b", i, wb_addr_ok, i < 4); end
            if (i < 4) tick();
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8 && !awvalid; k++) tick();
            n_cmp++;
            if (awvalid !== 1'b1 || awaddr !== a[i] || wdata !== d[i]) begin
                n_err++; $display("FAIL order[%0d] got v %b addr %h data %h exp addr %h data %h", i, awvalid, awaddr, wdata, a[i], d[i]);
            end
            awready = 1'b1; wready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
            #1;
            n_cmp++;
            if (bready !== 1'b1) begin n_err++; $display("FAIL b2b_bready[%0d] got %b exp 1", i, bready); end
            bvalid = 1'b1;
            #1;
            if (i == 0) begin
                n_cmp++;
                if (wb_addr_ok !== 1'b0) begin n_err++; $display("FAIL full_pop_ok got %b exp 0", wb_addr_ok); end
            end
            tick();
            bvalid = 1'b0;
            #1;
            if (i == 0) begin
                n_cmp++;
                if (wb_addr_ok !== 1'b1) begin n_err++; $display("FAIL after_pop_ok got %b exp 1", wb_addr_ok); end
                tick();
                wb_req = 1'b0;
                #1;
                n_cmp++;
                if (wb_addr_ok !== 1'b0) begin n_err++; $display("FAIL refull_ok got %b exp 0", wb_addr_ok); end
            end
        end
        tick();
        n_cmp++;
        if (wb_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got %b exp 1", wb_empty); end
    endtask

    task automatic test_split_handshake();
        wb_req = 1'b1; wb_addr = 32'h5000_0020; wb_wdata = 32'h1234_5678; wb_wstrb = 4'h3; wb_size = 3'd1;
        tick();
        wb_req = 1'b0;
        for (int k = 0; k < 4 && !awvalid; k++) tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if ({awvalid, wvalid, bready} !== 3'b010) begin n_err++; $display("FAIL split_wait[%0d] got %b exp 010", k, {awvalid, wvalid, bready}); end
            if (k < 2) tick();
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin n_err++; $display("FAIL split_done got %b exp 001", {awvalid, wvalid, bready}); end
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
    endtask

    task automatic test_q_hit();
        wb_req = 1'b1; wb_addr = 32'h1000_0004; wb_wdata = 32'hCAFE_F00D; wb_wstrb = 4'hF; wb_size = 3'd2;
        tick();
        wb_req = 1'b0;
        q_addr = 32'h1000_0007; #1;
        n_cmp++;
        if (q_hit !== 1'b1) begin n_err++; $display("FAIL qhit_same_word got %b exp 1", q_hit); end
        q_addr = 32'h1000_0008; #1;
        n_cmp++;
        if (q_hit !== 1'b0) begin n_err++; $display("FAIL qhit_next_word got %b exp 0", q_hit); end
        for (int k = 0; k < 4 && !awvalid; k++) tick();
        q_addr = 32'h1000_0004; #1;
        n_cmp++;
        if (q_hit !== 1'b1) begin n_err++; $display("FAIL qhit_inflight got %b exp 1", q_hit); end
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        #1;
        n_cmp++;
        if (q_hit !== 1'b0) begin n_err++; $display("FAIL qhit_after_b got %b exp 0", q_hit); end
    endtask

    task automatic test_random();
        st_t mq [$];
        bit  aw_seen = 0;
        bit  w_seen = 0;
        bit  exp_hit;
        bit  do_push;
        bit  do_pop;
        st_t e;
        for (int c = 0; c < 800; c++) begin
            wb_req   = c < 650 ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_addr  = 32'h4000_0000 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            wb_wdata = $urandom;
            wb_wstrb = 4'($urandom);
            wb_size  = 3'($urandom_range(0, 2));
            q_addr   = 32'h4000_0000 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            awready  = $urandom_range(0, 2) != 0;
            wready   = $urandom_range(0, 2) != 0;
            bvalid   = $urandom_range(0, 1) != 0;
            bid      = 4'($urandom);
            bresp    = 2'($urandom);
            #1;
            n_cmp++;
            if (wb_addr_ok !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ok c%0d got %b exp %b", c, wb_addr_ok, mq.size() < DEPTH); end
            n_cmp++;
            if (wb_empty !== (mq.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d got %b exp %b", c, wb_empty, mq.size() == 0); end
            exp_hit = 0;
            foreach (mq[j]) if (mq[j].addr[31:2] == q_addr[31:2]) exp_hit = 1;
            n_cmp++;
            if (q_hit !== exp_hit) begin n_err++; $display("FAIL rnd_qhit c%0d got %b exp %b", c, q_hit, exp_hit); end
            if (awvalid) begin
                n_cmp++;
                if (mq.size() == 0 || aw_seen || awaddr !== mq[0].addr || awsize !== mq[0].size) begin
                    n_err++; $display("FAIL rnd_aw c%0d got addr %h size %h", c, awaddr, awsize);
                end
            end
            if (wvalid) begin
                n_cmp++;
                if (mq.size() == 0 || w_seen || wdata !== mq[0].data || wstrb !== mq[0].strb) begin
                    n_err++; $display("FAIL rnd_w c%0d got data %h strb %h", c, wdata, wstrb);
                end
            end
            if (bready) begin
                n_cmp++;
                if (!(aw_seen && w_seen)) begin n_err++; $display("FAIL rnd_bready_early c%0d got aw %b w %b exp 11", c, aw_seen, w_seen); end
            end
            do_push = wb_req && mq.size() < DEPTH;
            do_pop  = bvalid && bready;
            if (awvalid && awready) aw_seen = 1;
            if (wvalid && wready) w_seen = 1;
            e = '{addr: wb_addr, data: wb_wdata, strb: wb_wstrb, size: wb_size};
            tick();
            if (do_pop) begin
                void'(mq.pop_front());
                aw_seen = 0;
                w_seen  = 0;
            end
            if (do_push) mq.push_back(e);
        end
        n_cmp++;
        if (mq.size() != 0 || wb_empty !== 1'b1) begin n_err++; $display("FAIL rnd_drain got left %0d empty %b exp 0 1", mq.size(), wb_empty); end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        wb_req = 1'b1; wb_addr = 32'h3000_0000; wb_wdata = 32'h0BAD_F00D; wb_wstrb = 4'hF; wb_size = 3'd2;
        tick();
        wb_req = 1'b0;
        for (int k = 0; k < 4 && !awvalid; k++) tick();
        n_cmp++;
        if (awvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_send got %b exp 1", awvalid); end
        rst = 1'b1; q_addr = 32'h3000_0000;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, wb_empty, q_hit} !== 5'b00010) begin
            n_err++; $display("FAIL rstmid got %b exp 00010", {awvalid, wvalid, bready, wb_empty, q_hit});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_split_handshake();
        test_q_hit();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
